pc_branch_unit: RTL

//  Consumer end of the ALU result interface. Holds the program counter and resolves branches/jumps.

---
 rtl/riscv_core_pkg.sv | 9 +
 rtl/event_counter.sv | 16 +
 rtl/pc_branch_unit.sv | 66 ++++++
 3 files changed

// File: rtl/riscv_core_pkg.sv
// riscv_core_pkg: shared state encoding, reset vector and branch ALU opcodes for the core.
package riscv_core_pkg;
  typedef enum logic [1:0] {ST_BOOT = 2'd0, ST_RUN = 2'd1, ST_TRAP = 2'd2} pc_state_t;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0040_0000;
  localparam logic [3:0] ALU_BEQ = 4'b1001;
  localparam logic [3:0] ALU_BNE = 4'b1010;
  localparam logic [3:0] ALU_BLT = 4'b1011;
  localparam logic [3:0] ALU_BGE = 4'b1100;
endpackage

// File: rtl/event_counter.sv
// event_counter: wrapping event counter with enable and synchronous active-low reset.
module event_counter #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_en,
  output logic [COUNT_WIDTH-1:0] o_count
);
  logic [COUNT_WIDTH-1:0] r_count;
  always_ff @(posedge clk) begin
    if (!reset) r_count <= '0;
    else if (i_en) r_count <= r_count + COUNT_WIDTH'(1);
  end
  assign o_count = r_count;
endmodule

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: program counter with branch/jump resolution, boot cycle, misalign trap and event counters.
module pc_branch_unit
  import riscv_core_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(RESET_VECTOR_DEF),
  parameter int                    COUNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Stall_i,
  input  logic                   Retire_i,
  input  logic                   Branch_i,
  input  logic                   Jal_i,
  input  logic                   Jalr_i,
  input  logic                   Zero_i,
  input  logic [DATA_WIDTH-1:0]  Imm_i,
  input  logic [DATA_WIDTH-1:0]  Rs1_Data_i,
  output logic [DATA_WIDTH-1:0]  PC_o,
  output logic [DATA_WIDTH-1:0]  PC_Plus_4_o,
  output logic                   Redirect_o,
  output logic                   Trap_o,
  output logic [DATA_WIDTH-1:0]  Trap_PC_o,
  output logic [COUNT_WIDTH-1:0] Taken_Count_o,
  output logic [COUNT_WIDTH-1:0] Retired_Count_o
);
  pc_state_t             r_state, w_state_next;
  logic [DATA_WIDTH-1:0] r_pc, r_trap_pc, w_jalr_sum, w_target;
  logic                  w_run, w_redirect_raw, w_adv, w_mis, w_commit;
  assign w_run          = r_state == ST_RUN;
  assign w_redirect_raw = Jalr_i | Jal_i | (Branch_i & Zero_i);
  assign w_jalr_sum     = Rs1_Data_i + Imm_i;
  // Jalr outranks Jal, which outranks a taken branch
  assign w_target = Jalr_i ? {w_jalr_sum[DATA_WIDTH-1:1], 1'b0}
                  : w_redirect_raw ? r_pc + Imm_i
                  : PC_Plus_4_o;
  assign w_adv    = w_run & Retire_i & ~Stall_i;
  assign w_mis    = |w_target[1:0];
  assign w_commit = w_adv & ~w_mis;
  always_comb begin
    w_state_next = r_state;
    w_state_next = r_state == ST_BOOT ? ST_RUN : (w_adv & w_mis) ? ST_TRAP : r_state;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_BOOT;
      r_pc      <= RESET_VECTOR;
      r_trap_pc <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_commit) r_pc <= w_target;
      if (w_adv & w_mis) r_trap_pc <= r_pc;
    end
  end
  event_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_taken_cnt (
    .clk(clk), .reset(reset), .i_en(w_commit & w_redirect_raw), .o_count(Taken_Count_o)
  );
  event_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_retired_cnt (
    .clk(clk), .reset(reset), .i_en(w_commit), .o_count(Retired_Count_o)
  );
  assign PC_o        = r_pc;
  assign PC_Plus_4_o = r_pc + DATA_WIDTH'(4);
  assign Redirect_o  = w_run & w_redirect_raw;
  assign Trap_o      = r_state == ST_TRAP;
  assign Trap_PC_o   = r_trap_pc;
endmodule
